// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: 32-bit load/store over a 16-bit SRAM (LO then HI half, SRAM_WAIT extra cycles each); MEM_ADDR_OFFSET_EN rebases data at byte 1024.
// Latency: non-memory ops 0 stall; memory ops assert freeze_out for 2*(SRAM_WAIT+1)+1 cycles, results load in DONE.
module mem_stage_sram_ctrl #(
  parameter int unsigned SRAM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_Rm_in,
  input  logic [3:0]  dest_in,
  output logic        freeze_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [2:0] WAIT_LD = 3'(SRAM_WAIT);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [15:0] rd_lo, rd_hi;
  logic [31:0] eff_addr;
  logic        req, is_rd, is_wr;
  logic        unused_addr_bits;

`ifdef MEM_ADDR_OFFSET_EN
  assign eff_addr = alu_res_in - 32'd1024;
`else
  assign eff_addr = alu_res_in;
`endif

  assign unused_addr_bits = ^{eff_addr[31:19], eff_addr[1:0]};

  // A simultaneous read and write request is treated as a read.
  assign req   = mem_r_en_in | mem_w_en_in;
  assign is_rd = mem_r_en_in;
  assign is_wr = mem_w_en_in & ~mem_r_en_in;

  assign freeze_out = ~rst & req & (state != DONE);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sram_addr  = 18'd0;
    sram_we_n  = 1'b1;
    sram_wdata = 16'd0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LO;
          cnt_nxt   = WAIT_LD;
        end
      end
      LO: begin
        sram_addr  = {eff_addr[18:2], 1'b0};
        sram_we_n  = ~is_wr;
        sram_wdata = is_wr ? val_Rm_in[15:0] : 16'd0;
        if (cnt == 3'd0) begin
          state_nxt = HI;
          cnt_nxt   = WAIT_LD;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      HI: begin
        sram_addr  = {eff_addr[18:2], 1'b1};
        sram_we_n  = ~is_wr;
        sram_wdata = is_wr ? val_Rm_in[31:16] : 16'd0;
        if (cnt == 3'd0) begin
          state_nxt = DONE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      rd_lo <= 16'd0;
      rd_hi <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Each half is captured on the final wait cycle of its phase.
      if (state == LO && cnt == 3'd0 && is_rd) rd_lo <= sram_rdata;
      if (state == HI && cnt == 3'd0 && is_rd) rd_hi <= sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= 32'd0;
      mem_data_out <= 32'd0;
      dest_out     <= 4'd0;
    end else if (freeze_out) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
    end else begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      alu_res_out  <= alu_res_in;
      dest_out     <= dest_in;
      if (state == DONE && is_rd) mem_data_out <= {rd_hi, rd_lo};
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed cases plus random ops against a per-op timing/memory model.
module tb_mem_stage_sram_ctrl;
  localparam int W     = 1;
  localparam int L_MEM = 2 * (W + 1) + 2;
`ifdef MEM_ADDR_OFFSET_EN
  localparam logic [31:0] OFS = 32'd1024;
`else
  localparam logic [31:0] OFS = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_Rm_in;
  logic [3:0]  dest_in;
  logic        freeze_out, wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_we_n;

  // second instance with zero wait states, store-only
  logic        z_rst, z_w;
  logic [31:0] z_alu, z_val;
  logic        z_frz, z_wb_out, z_mr_out;
  logic [31:0] z_alu_out, z_md_out;
  logic [3:0]  z_dest_out;
  logic [17:0] z_addr;
  logic [15:0] z_wd;
  logic        z_we_n;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.SRAM_WAIT(W)) u_dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in),
    .dest_in(dest_in), .freeze_out(freeze_out), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out), .mem_data_out(mem_data_out),
    .dest_out(dest_out), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_we_n(sram_we_n));

  mem_stage_sram_ctrl #(.SRAM_WAIT(0)) u_dut0 (
    .clk(clk), .rst(z_rst), .wb_en_in(1'b0), .mem_r_en_in(1'b0),
    .mem_w_en_in(z_w), .alu_res_in(z_alu), .val_Rm_in(z_val),
    .dest_in(4'd2), .freeze_out(z_frz), .wb_en_out(z_wb_out),
    .mem_r_en_out(z_mr_out), .alu_res_out(z_alu_out), .mem_data_out(z_md_out),
    .dest_out(z_dest_out), .sram_addr(z_addr), .sram_wdata(z_wd),
    .sram_rdata(16'h0000), .sram_we_n(z_we_n));

  int n_cmp = 0, n_bad = 0;
  int fr_cnt = 0, wb_cnt = 0;
  logic [15:0] sram [0:255];
  logic [15:0] mmem [0:255];
  logic [17:0] zq_a[$];
  logic [15:0] zq_d[$];

  logic        chk_en = 1'b0;
  logic        e_frz, e_we_n, e_wb, e_mr;
  logic [17:0] e_addr;
  logic [15:0] e_wd;
  logic [31:0] e_alu, e_md;
  logic [3:0]  e_dest;

  assign sram_rdata = sram[sram_addr[7:0]];

  always @(posedge clk) if (!sram_we_n) sram[sram_addr[7:0]] <= sram_wdata;
  always @(posedge clk) if (!z_we_n && !z_rst) begin
    zq_a.push_back(z_addr);
    zq_d.push_back(z_wd);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (freeze_out) fr_cnt++;
    if (wb_en_out) wb_cnt++;
    if (chk_en) begin
      check("freeze_out",   {31'd0, freeze_out},   {31'd0, e_frz});
      check("sram_addr",    {14'd0, sram_addr},    {14'd0, e_addr});
      check("sram_we_n",    {31'd0, sram_we_n},    {31'd0, e_we_n});
      check("sram_wdata",   {16'd0, sram_wdata},   {16'd0, e_wd});
      check("wb_en_out",    {31'd0, wb_en_out},    {31'd0, e_wb});
      check("mem_r_en_out", {31'd0, mem_r_en_out}, {31'd0, e_mr});
      check("alu_res_out",  alu_res_out,           e_alu);
      check("mem_data_out", mem_data_out,          e_md);
      check("dest_out",     {28'd0, dest_out},     {28'd0, e_dest});
    end
  end

  // One instruction, presented until the block accepts it. rst_at >= 0 pulses
  // rst in that cycle and abandons the op.
  task automatic run_instr(input logic r, input logic w, input logic wb,
                           input logic [31:0] alu, input logic [31:0] val,
                           input logic [3:0] dest, input int rst_at);
    logic        mem_op, wr;
    int          len;
    logic [31:0] a;
    logic [7:0]  lo;
    mem_op = r | w;
    wr     = w & ~r;
    len    = mem_op ? L_MEM : 1;
    a      = alu - OFS;
    lo     = {a[8:2], 1'b0};
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = alu; val_Rm_in = val; dest_in = dest;
    for (int k = 0; k < len; k++) begin
      e_frz = mem_op && (k < len - 1);
      e_addr = 18'd0; e_we_n = 1'b1; e_wd = 16'd0;
      if (mem_op && k >= 1 && k <= W + 1) begin
        e_addr = {a[18:2], 1'b0}; e_we_n = ~wr; e_wd = wr ? val[15:0] : 16'd0;
      end else if (mem_op && k >= W + 2 && k <= 2 * W + 2) begin
        e_addr = {a[18:2], 1'b1}; e_we_n = ~wr; e_wd = wr ? val[31:16] : 16'd0;
      end
      if (k == rst_at) begin
        rst = 1'b1; chk_en = 1'b0;
        @(negedge clk);
        check("freeze_during_rst", {31'd0, freeze_out}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_we_n",   {31'd0, sram_we_n}, 32'd1);
        check("rst_addr",   {14'd0, sram_addr}, 32'd0);
        check("rst_wb",     {31'd0, wb_en_out}, 32'd0);
        check("rst_mr",     {31'd0, mem_r_en_out}, 32'd0);
        check("rst_alu",    alu_res_out, 32'd0);
        check("rst_md",     mem_data_out, 32'd0);
        check("rst_dest",   {28'd0, dest_out}, 32'd0);
        e_wb = 0; e_mr = 0; e_alu = 0; e_md = 0; e_dest = 0;
        chk_en = 1'b1;
        return;
      end
      @(posedge clk); #1;
      if (k < len - 1) begin
        e_wb = 1'b0; e_mr = 1'b0;
      end else begin
        e_wb = wb; e_mr = r; e_alu = alu; e_dest = dest;
        if (r) e_md = {mmem[lo + 8'd1], mmem[lo]};
      end
    end
    if (wr) begin
      mmem[lo] = val[15:0];
      mmem[lo + 8'd1] = val[31:16];
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, w0, zf, zw, zb;
    logic [31:0] a;
    int kind;
    for (int i = 0; i < 256; i++) begin
      sram[i] = 16'($urandom);
      mmem[i] = sram[i];
    end
    sram[4] = 16'hBEEF; mmem[4] = 16'hBEEF;
    sram[5] = 16'hDEAD; mmem[5] = 16'hDEAD;
    e_frz = 0; e_we_n = 1; e_addr = 0; e_wd = 0;
    e_wb = 0; e_mr = 0; e_alu = 0; e_md = 0; e_dest = 0;
    z_rst = 1; z_w = 0; z_alu = 0; z_val = 0;
    rst = 1; wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 0;
    alu_res_in = 32'h8 + OFS; val_Rm_in = 0; dest_in = 4'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_freeze", {31'd0, freeze_out}, 32'd0);
    check("reset_we_n",   {31'd0, sram_we_n}, 32'd1);
    check("reset_addr",   {14'd0, sram_addr}, 32'd0);
    check("reset_wb",     {31'd0, wb_en_out}, 32'd0);
    check("reset_md",     mem_data_out, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    chk_en = 1;

    // ADD passes straight through
    f0 = fr_cnt;
    run_instr(0, 0, 1, 32'h7, 32'h0, 4'd3, -1);
    check("add_alu", alu_res_out, 32'h7);
    check("add_dest", {28'd0, dest_out}, 32'd3);
    check("add_wb", {31'd0, wb_en_out}, 32'd1);
    check("add_freeze_cycles", fr_cnt - f0, 32'd0);

    // load of SRAM[4..5]
    f0 = fr_cnt;
    run_instr(1, 0, 1, 32'h8 + OFS, 32'h0, 4'd5, -1);
    check("ld_freeze_cycles", fr_cnt - f0, 32'd5);
    check("ld_data", mem_data_out, 32'hDEADBEEF);
    check("ld_wb", {31'd0, wb_en_out}, 32'd1);

    // load immediately followed by store
    run_instr(0, 0, 0, 32'h0, 32'h0, 4'd0, -1);
    f0 = fr_cnt; w0 = wb_cnt;
    run_instr(1, 0, 1, 32'h20 + OFS, 32'h0, 4'd6, -1);
    run_instr(0, 1, 0, 32'h24 + OFS, 32'hCAFEF00D, 4'd0, -1);
    check("b2b_freeze_cycles", fr_cnt - f0, 32'd10);
    check("b2b_wb_pulses", wb_cnt - w0, 32'd1);

    // reset in the first HI cycle of a load, then the same load again
    run_instr(1, 0, 1, 32'h30 + OFS, 32'h0, 4'd7, W + 2);
    f0 = fr_cnt;
    run_instr(1, 0, 1, 32'h30 + OFS, 32'h0, 4'd7, -1);
    check("post_rst_freeze_cycles", fr_cnt - f0, 32'd5);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      a = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
      if (kind < 4)
        run_instr(0, 0, 1'($urandom), $urandom, $urandom, 4'($urandom), -1);
      else if (kind < 7)
        run_instr(1, 0, 1'($urandom), a + OFS, $urandom, 4'($urandom), -1);
      else if (kind < 9)
        run_instr(0, 1, 1'($urandom), a + OFS, $urandom, 4'($urandom), -1);
      else
        run_instr(1, 1, 1'($urandom), a + OFS, $urandom, 4'($urandom), -1);
    end
    run_instr(0, 0, 0, 32'h0, 32'h0, 4'd0, -1);
    chk_en = 0;

    // zero-wait store on the second instance
    zf = 0; zw = 0; zb = 0;
    z_rst = 0; z_w = 1; z_alu = 32'h10 + OFS; z_val = 32'h12345678;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) z_w = 0;
      @(negedge clk);
      if (z_frz) zf++;
      if (!z_we_n) zw++;
      if (z_wb_out) zb++;
      @(posedge clk); #1;
    end
    check("st0_freeze_cycles", zf, 32'd3);
    check("st0_we_low_cycles", zw, 32'd2);
    check("st0_wb_cycles", zb, 32'd0);
    check("st0_write_count", zq_a.size(), 32'd2);
    if (zq_a.size() == 2) begin
      check("st0_addr0", {14'd0, zq_a[0]}, 32'd8);
      check("st0_data0", {16'd0, zq_d[0]}, 32'h5678);
      check("st0_addr1", {14'd0, zq_a[1]}, 32'd9);
      check("st0_data1", {16'd0, zq_d[1]}, 32'h1234);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_sram_ctrl.md
MEM_STAGE_SRAM_CTRL -- requirements
Module: mem_stage_sram_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter SRAM_WAIT, default 1, range 0..7: extra wait cycles per 16-bit SRAM half-access.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  control bits from the EX pipeline register.
REQ-006 alu_res_in  input  32  byte address for loads/stores, or ALU result to forward.
REQ-007 val_Rm_in  input  32  store data.
REQ-008 dest_in  input  4  destination register index.
REQ-009 freeze_out  output  1  stall request to the PC, IF, ID and EX stages.
REQ-010 wb_en_out, mem_r_en_out  output  1 each  registered to WB.
REQ-011 alu_res_out, mem_data_out  output  32 each  registered to WB.
REQ-012 dest_out  output  4  registered to WB.
REQ-013 sram_addr  output  18  SRAM half-word address.
REQ-014 sram_wdata  output  16  SRAM write data; sram_rdata  input  16  SRAM read data.
REQ-015 sram_we_n  output  1  SRAM write strobe, active low.

Function
REQ-016 The FSM SHALL use states IDLE, LO, HI and DONE; wait counter width 3.
REQ-017 The request SHALL be mem_r_en_in | mem_w_en_in; when both are high it is a read and the write is ignored.
REQ-018 Effective address: A = alu_res_in, or as modified by REQ-033.
REQ-019 sram_addr SHALL be {A[18:2], half}; half = 0 in LO and 1 in HI.
REQ-020 IDLE with a request: next state LO and counter loaded with SRAM_WAIT; IDLE without a request: stay IDLE.
REQ-021 LO/HI: hold the address for SRAM_WAIT+1 cycles and decrement the counter.
  - At counter 0, LO goes to HI (counter reloaded) and HI goes to DONE.
REQ-022 Read: sram_rdata SHALL be sampled on the last LO cycle into data[15:0] and on the last HI cycle into data[31:16].
REQ-023 Write: sram_we_n SHALL be low in every LO/HI cycle and high in all other states.
  - sram_wdata = val_Rm_in[15:0] in LO and val_Rm_in[31:16] in HI; 0 otherwise.
REQ-024 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-025 freeze_out SHALL be combinational: high when a request is present and state != DONE; low when rst is high.
REQ-026 A memory op SHALL hold freeze_out high for exactly 2*(SRAM_WAIT+1)+1 cycles, counted from the first cycle it is presented.
REQ-027 Non-memory instructions SHALL pass with zero added stall.
  - The output register loads inputs on the next edge, with mem_data_out unchanged.
REQ-028 While freeze_out is high, the output register SHALL load a bubble.
  - wb_en_out = 0 and mem_r_en_out = 0; alu_res_out, mem_data_out and dest_out hold.
REQ-029 In DONE, the output register SHALL load wb_en_in, mem_r_en_in, alu_res_in and dest_in.
  - mem_data_out = assembled read data for a read; unchanged for a write.
REQ-030 Back-to-back memory ops SHALL be accepted in the IDLE cycle immediately following DONE.
REQ-031 Upstream SHALL hold all inputs stable while freeze_out is high; the block does not re-latch them.

Reset
REQ-032 On rst, including mid-access, the block SHALL enter IDLE at the next edge.
  - Counter = 0, sram_we_n = 1, sram_addr = 0, sram_wdata = 0.
  - All registered outputs = 0; any partial read data is discarded.

Configuration
REQ-033 Macro MEM_ADDR_OFFSET_EN controls the effective address.
  - Defined: A = alu_res_in - 32'd1024, so data memory starts at byte 1024.
  - Undefined: A = alu_res_in with no arithmetic.

Verification
REQ-034 SRAM_WAIT=1, load alu_res_in=0x00000408 with MEM_ADDR_OFFSET_EN, SRAM[4]=0xBEEF, SRAM[5]=0xDEAD.
  - freeze_out high 5 cycles; sram_addr 4 then 5; mem_data_out=0xDEADBEEF and wb_en_out=1 after DONE.
REQ-035 SRAM_WAIT=0, store val_Rm_in=0x12345678 to address 0x10, macro undefined.
  - sram_we_n low 2 cycles; writes 0x5678 at addr 8 then 0x1234 at addr 9; freeze_out high 3 cycles; wb_en_out=0 throughout.
REQ-036 ADD with wb_en_in=1, alu_res_in=0x7, dest_in=3: freeze_out stays 0.
  - Next edge: alu_res_out=0x7, dest_out=3, wb_en_out=1.
REQ-037 rst asserted during the HI state of a load.
  - Next edge: IDLE, sram_we_n=1, all outputs 0; a fresh load afterwards completes with full latency.
REQ-038 Load immediately followed by a store (SRAM_WAIT=1): the store begins in the cycle after DONE.
  - Total freeze 10 cycles; exactly one wb_en_out pulse.
